// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer and centre-of-bit sampling.
// It holds one byte until the consumer acknowledges it and flags lost bytes (overrun) and bad stop bits (frame_err).
//
// state     | meaning
// WAIT_IDLE | waiting for a genuine high line before arming start detection
// IDLE      | line idle, watching for a falling edge
// START     | half-bit wait, then confirm the start bit is still low
// DATA      | sampling 8 data bits, LSB first
// STOP      | sampling the stop bit, then delivering or flagging the frame
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state, state_nx;
    logic [1:0]      sync;
    logic [1:0]      fill;
    logic            rx_s;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_val;
    logic            cnt_load;
    logic            tick;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            shift_en;
    logic            stop_good;
    logic            stop_bad;
    logic            deliver;
    logic            lost;
    logic            consume;

    assign rx_s = sync[1];
    assign tick = (cnt == CW'(1));

    // fill marks when rx_s carries real line data rather than the reset value,
    // so a line held low through reset release never looks like a start edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync <= 2'b11;
            fill <= 2'b00;
        end else begin
            sync <= {sync[0], rx};
            fill <= {fill[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= WAIT_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            WAIT_IDLE: if (fill[1] && rx_s) state_nx = IDLE;
            IDLE:      if (!rx_s) state_nx = START;
            START:     if (tick) state_nx = rx_s ? IDLE : DATA;
            DATA:      if (tick && (bit_idx == 3'd7)) state_nx = STOP;
            STOP:      if (tick) state_nx = rx_s ? IDLE : WAIT_IDLE;
            default:   state_nx = WAIT_IDLE;
        endcase
    end

    always_comb begin
        cnt_load  = 1'b0;
        cnt_val   = '0;
        shift_en  = 1'b0;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    cnt_load = 1'b1;
                    cnt_val  = HALF;
                end
            end
            START: begin
                if (tick && !rx_s) begin
                    cnt_load = 1'b1;
                    cnt_val  = FULL;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = FULL;
                end
            end
            STOP: begin
                if (tick) begin
                    stop_good = rx_s;
                    stop_bad  = !rx_s;
                end
            end
            default: begin
                cnt_load = 1'b0;
            end
        endcase
    end

    // Load value N expires on the Nth edge after loading (terminal count 1).
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            if (cnt_load) begin
                cnt <= cnt_val;
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (state != DATA) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                shift[bit_idx] <= rx_s;
            end
        end
    end

    assign deliver = stop_good && (!rx_valid || rx_ack);
    assign lost    = stop_good && rx_valid && !rx_ack;
    assign consume = rx_valid && rx_ack;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            if (deliver) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (consume) begin
                rx_valid <= 1'b0;
            end
            if (lost) begin
                overrun <= 1'b1;
            end else if (consume) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit: stimulus pushes expected events,
// a negedge monitor pops and compares every delivery or frame error the DUT presents.
module tb_uart_rx;

    logic       clk;
    logic       nrst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       frame_err;
    logic       overrun;

    int compared = 0;
    int mismatched = 0;

    // {is_frame_err, data}
    logic [8:0] exp_q[$];

    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_fe = 1'b0;
    int         lat;

    uart_rx #(.CLKS_PER_BIT(16)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ack   (rx_ack),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [8:0] got;
        logic [8:0] want;
        if (frame_err || (rx_valid && (!prev_valid || rx_data != prev_data))) begin
            got = frame_err ? {1'b1, 8'h00} : {1'b0, rx_data};
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_event: got %0h required none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    mismatched++;
                    $display("FAIL event: got %0h required %0h", got, want);
                end
            end
        end
        if (prev_fe) begin
            compared++;
            if (frame_err !== 1'b0) begin
                mismatched++;
                $display("FAIL frame_err_width: got %0b required 0", frame_err);
            end
        end
        prev_valid = rx_valid;
        prev_data  = rx_data;
        prev_fe    = frame_err;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; leaves the stop-bit level on the line.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic ack_stop);
        rx = 1'b0;
        idle(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(16);
        end
        rx = stop_bit;
        if (ack_stop) begin
            idle(10);
            rx_ack = 1'b1;
            idle(1);
            rx_ack = 1'b0;
            idle(5);
        end else begin
            idle(16);
        end
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        idle(1);
        rx_ack = 1'b0;
    endtask

    initial begin
        nrst   = 1'b0;
        rx     = 1'b1;
        rx_ack = 1'b0;
        idle(4);
        check("reset_rx_valid", 32'(rx_valid), 0);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_frame_err", 32'(frame_err), 0);
        check("reset_overrun", 32'(overrun), 0);
        nrst = 1'b1;
        idle(20);

        // Basic byte with latency measured from the falling edge.
        exp_q.push_back({1'b0, 8'hA5});
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                while (lat < 300) begin
                    @(posedge clk);
                    lat++;
                    #1;
                    if (rx_valid) break;
                end
            end
        join
        check("latency_a5", 32'(lat), 155);
        check("overrun_a5", 32'(overrun), 0);
        ack_pulse();
        check("valid_after_ack", 32'(rx_valid), 0);
        ack_pulse();
        check("ack_idle_valid", 32'(rx_valid), 0);
        check("ack_idle_data", 32'(rx_data), 32'hA5);

        // False start, then a normal byte.
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(40);
        check("false_start_valid", 32'(rx_valid), 0);
        exp_q.push_back({1'b0, 8'h3C});
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(4);
        ack_pulse();

        // Bad stop bit, line held low, then recovery.
        exp_q.push_back({1'b1, 8'h00});
        send_frame(8'h55, 1'b0, 1'b0);
        idle(40);
        check("fe_valid", 32'(rx_valid), 0);
        rx = 1'b1;
        idle(20);
        exp_q.push_back({1'b0, 8'h0F});
        send_frame(8'h0F, 1'b1, 1'b0);
        idle(4);
        ack_pulse();

        // Overrun: second byte is lost.
        exp_q.push_back({1'b0, 8'h11});
        send_frame(8'h11, 1'b1, 1'b0);
        idle(4);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(4);
        check("ovr_valid", 32'(rx_valid), 1);
        check("ovr_data", 32'(rx_data), 32'h11);
        check("ovr_flag", 32'(overrun), 1);
        ack_pulse();
        check("ovr_clear_valid", 32'(rx_valid), 0);
        check("ovr_clear_flag", 32'(overrun), 0);

        // Back-to-back with ack on the stop-sample cycle.
        exp_q.push_back({1'b0, 8'h11});
        send_frame(8'h11, 1'b1, 1'b0);
        idle(4);
        exp_q.push_back({1'b0, 8'h22});
        send_frame(8'h22, 1'b1, 1'b1);
        idle(2);
        check("b2b_valid", 32'(rx_valid), 1);
        check("b2b_data", 32'(rx_data), 32'h22);
        check("b2b_overrun", 32'(overrun), 0);
        ack_pulse();

        // Reset mid-frame with the line low through release.
        idle(10);
        rx = 1'b0;
        idle(16);
        rx = 1'b1;
        idle(4 * 16 + 8);
        rx = 1'b0;
        nrst = 1'b0;
        idle(5);
        check("midrst_valid", 32'(rx_valid), 0);
        nrst = 1'b1;
        idle(200);
        check("post_rst_valid", 32'(rx_valid), 0);
        rx = 1'b1;
        idle(20);
        exp_q.push_back({1'b0, 8'h81});
        send_frame(8'h81, 1'b1, 1'b0);
        idle(4);
        check("final_data", 32'(rx_data), 32'h81);
        ack_pulse();
        idle(10);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range 4..65535; even values only.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 nrst  input  1  reset, asynchronous assert, active-low.
REQ-004 rx  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-005 rx_data  output  8  received byte; stable while rx_valid=1.
REQ-006 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-007 rx_ack  input  1  consumer accepts rx_data; effective only on a cycle with rx_valid=1.
REQ-008 frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-009 overrun  output  1  sticky flag: a byte was lost because rx_valid was still set.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; rx_s denotes the synchronizer output (2-cycle latency); only rx_s is used internally.
REQ-011 FSM states SHALL be WAIT_IDLE, IDLE, START, DATA, STOP.
REQ-012 WAIT_IDLE: go to IDLE on the first cycle rx_s=1; no start detection while in WAIT_IDLE.
REQ-013 IDLE: rx_s=0 -> START, with the bit counter loaded for CLKS_PER_BIT/2 cycles.
REQ-014 START: at counter expiry, sample rx_s.
- 1: false start -> IDLE, no output activity.
- 0: -> DATA, with counter loaded for CLKS_PER_BIT cycles and bit index 0.
REQ-015 DATA: at each counter expiry, sample rx_s into shift bit [index]; reload the counter.
- After index 7, go to STOP.
- Samples SHALL fall at bit centres: CLKS_PER_BIT/2 + k*CLKS_PER_BIT cycles after the start edge at rx_s.
REQ-016 STOP: at counter expiry, sample rx_s.
- 1: deliver the byte (REQ-017), go to IDLE.
- 0: pulse frame_err for 1 cycle, discard the byte, go to WAIT_IDLE.
REQ-017 Delivery, in the cycle after the stop sample:
- rx_valid=0, or rx_ack=1 in the stop-sample cycle: rx_data<=byte, rx_valid<=1.
- Otherwise: keep the old rx_data, discard the new byte, set overrun<=1.
REQ-018 Consumption: on a posedge with rx_valid=1 and rx_ack=1, clear rx_valid on that same edge, unless a delivery occurs on that edge, in which case rx_valid stays 1 with the new data.
REQ-019 overrun SHALL clear only on a consumption edge (REQ-018) or on reset; a set and a clear on the same edge -> set wins.
REQ-020 rx_ack while rx_valid=0 SHALL have no effect.
REQ-021 Counter width SHALL be ceil(log2(CLKS_PER_BIT+1)) bits; no wrap inside a bit period.
REQ-022 Glitches on rx_s during DATA/STOP between sample points SHALL be ignored.

Reset
REQ-023 While nrst=0, the block SHALL hold these values:
- synchronizer flops = 1
- state = WAIT_IDLE
- rx_data = 8'h00
- rx_valid, frame_err, overrun = 0
- counters = 0
REQ-024 Reset asserted mid-frame SHALL abort the frame with no delivery; after release, no start is detected until rx_s has been 1 for at least one cycle.

Verification (CLKS_PER_BIT=16)
REQ-025 Send 8'hA5 (start, 1,0,1,0,0,1,0,1, stop):
- rx_valid rises 2+8+16*9+1 cycles after the rx falling edge, with rx_data=8'hA5;
- frame_err=0; overrun=0.
REQ-026 Drive a 5-cycle low pulse on idle rx -> false start; rx_valid, frame_err and the FSM return to idle; a following 8'h3C is received correctly.
REQ-027 Send 8'h55 with stop bit 0 -> frame_err pulses exactly 1 cycle; rx_valid stays 0; a following 8'h0F is received only after rx is held high.
REQ-028 Send 8'h11 with no ack, then 8'h22 -> rx_data=8'h11, overrun=1; an rx_ack pulse clears rx_valid and overrun.
REQ-029 Back-to-back: send 8'h11, then 8'h22 with rx_ack=1 in the stop-sample cycle of 8'h22 -> rx_data=8'h22, rx_valid stays 1, overrun=0.
REQ-030 Assert nrst during bit 4 of 8'hFF while rx is low -> no delivery; after release with rx still low, no reception until rx goes high; a following 8'h81 is received correctly.
